// File: rtl/fir_mac_scheduler.sv
// Sequencer for a two-channel decimating FIR sharing one MAC: owns the sample write
// pointer, decimation count, per-output read/coefficient sweep and accumulator strobes.
module fir_mac_scheduler #(
    parameter int RATE       = 8,
    parameter int NUM_TAPS   = 199,
    parameter int ADDR_WIDTH = 8,
    parameter int COEF_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  ovr_clr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [COEF_WIDTH-1:0] coef_idx,
    output logic                  ch_sel,
    output logic                  mac_en,
    output logic                  mac_clear,
    output logic                  dump,
    output logic                  dump_ch,
    output logic                  busy,
    output logic                  overrun
);
    localparam int DECI_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [DECI_W-1:0]     DECI_LAST = DECI_W'(RATE - 1);
    localparam logic [COEF_WIDTH-1:0] K_LAST    = COEF_WIDTH'(NUM_TAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(NUM_TAPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state;
    logic [DECI_W-1:0]       deci_cnt;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic                    flush_cnt;
    logic                    last_k;
    logic                    last_ch;
    logic                    trigger;

    assign wr_en   = in_valid & ~reset;
    assign trigger = in_valid && (deci_cnt == DECI_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            deci_cnt   <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            start_addr <= '0;
            coef_idx   <= '0;
            ch_sel     <= 1'b0;
            flush_cnt  <= 1'b0;
            mac_en     <= 1'b0;
            mac_clear  <= 1'b0;
            last_k     <= 1'b0;
            last_ch    <= 1'b0;
            dump       <= 1'b0;
            dump_ch    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (in_valid) begin
                wr_addr  <= wr_addr + 1'b1;
                deci_cnt <= trigger ? '0 : deci_cnt + 1'b1;
            end

            if (trigger && state != IDLE)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            // Read issue is one cycle ahead of RAM q; these strobes follow it by one.
            mac_en    <= (state == RUN);
            mac_clear <= (state == RUN) && (coef_idx == '0);
            last_k    <= (state == RUN) && (coef_idx == K_LAST);
            last_ch   <= ch_sel;
            dump      <= last_k;
            if (last_k)
                dump_ch <= last_ch;

            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        start_addr <= wr_addr - SPAN;
                        rd_addr    <= wr_addr - SPAN;
                        coef_idx   <= '0;
                        ch_sel     <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (coef_idx == K_LAST) begin
                        coef_idx <= '0;
                        rd_addr  <= start_addr;
                        if (ch_sel) begin
                            flush_cnt <= 1'b0;
                            state     <= FLUSH;
                        end else begin
                            ch_sel <= 1'b1;
                        end
                    end else begin
                        coef_idx <= coef_idx + 1'b1;
                        rd_addr  <= rd_addr + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        flush_cnt <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: two configurations, each with a modelled RAM/ROM/MAC
// datapath, a timeline-based reference model and directed literal checks.
module tb_fir_mac_scheduler;
    bit clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done [2];

    task automatic check(input int cfg, input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0d expected %0d", cfg, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int G  = g;
        localparam int R  = (g == 0) ? 8 : 1;
        localparam int N  = (g == 0) ? 199 : 4;
        localparam int AW = (g == 0) ? 8 : 3;
        localparam int CW = (g == 0) ? 8 : 2;
        localparam int D  = 1 << AW;

        logic          rst = 1'b1;
        logic          in_valid = 1'b0;
        logic          ovr_clr = 1'b0;
        int            s0 = 0;
        int            s1 = 0;
        logic          wr_en, ch_sel, mac_en, mac_clear, dump, dump_ch, busy, overrun;
        logic [AW-1:0] wr_addr, rd_addr;
        logic [CW-1:0] coef_idx;

        fir_mac_scheduler #(.RATE(R), .NUM_TAPS(N), .ADDR_WIDTH(AW), .COEF_WIDTH(CW)) dut (
            .clk(clk), .reset(rst), .in_valid(in_valid), .ovr_clr(ovr_clr),
            .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .coef_idx(coef_idx),
            .ch_sel(ch_sel), .mac_en(mac_en), .mac_clear(mac_clear), .dump(dump),
            .dump_ch(dump_ch), .busy(busy), .overrun(overrun)
        );

        function automatic int coefv(input int k);
            return (G == 0) ? 1 : k + 1;
        endfunction

        // Datapath: two sample banks prefilled with +1/-1, registered ROM, MAC.
        int ram0 [D];
        int ram1 [D];
        int q = 0, cq = 0, acc = 0;
        bit dp_init = 1'b0;
        always @(posedge clk) begin
            if (!dp_init) begin
                for (int i = 0; i < D; i++) begin
                    ram0[i] <= 1;
                    ram1[i] <= -1;
                end
                dp_init <= 1'b1;
            end
            if (wr_en) begin
                ram0[wr_addr] <= s0;
                ram1[wr_addr] <= s1;
            end
            q  <= ch_sel ? ram1[rd_addr] : ram0[rd_addr];
            cq <= coefv(int'(coef_idx));
            if (mac_en)
                acc <= mac_clear ? q * cq : acc + q * cq;
        end

        // Reference: jobs as a timeline anchored at the accepted trigger cycle.
        int m_mem0 [D];
        int m_mem1 [D];
        int m_wr = 0, m_deci = 0, m_cyc = 0, m_T = -100000, m_base = 0, exp0 = 0, exp1 = 0;
        bit m_ovr = 1'b0, m_rst = 1'b0, m_init = 1'b0;
        initial begin
            bit trig, active;
            int a;
            forever begin
                @(posedge clk);
                if (!m_init) begin
                    for (int i = 0; i < D; i++) begin
                        m_mem0[i] = 1;
                        m_mem1[i] = -1;
                    end
                    m_init = 1'b1;
                end
                m_rst = rst;
                if (rst) begin
                    m_wr = 0; m_deci = 0; m_ovr = 1'b0; m_T = -100000;
                end else begin
                    trig   = in_valid && (m_deci == R - 1);
                    active = (m_cyc - m_T) <= 2 * N + 2;
                    if (in_valid) begin
                        m_mem0[m_wr] = s0;
                        m_mem1[m_wr] = s1;
                    end
                    if (trig && active) begin
                        m_ovr = 1'b1;
                    end else begin
                        if (ovr_clr) m_ovr = 1'b0;
                        if (trig) begin
                            m_T = m_cyc; m_base = m_wr; exp0 = 0; exp1 = 0;
                            for (int k = 0; k < N; k++) begin
                                a = ((m_wr - (N - 1) + k) % D + D) % D;
                                exp0 += m_mem0[a] * coefv(k);
                                exp1 += m_mem1[a] * coefv(k);
                            end
                        end
                    end
                    if (in_valid) begin
                        m_wr   = (m_wr + 1) % D;
                        m_deci = (m_deci + 1) % R;
                    end
                end
                m_cyc++;
            end
        end

        initial begin
            int d, j;
            forever begin
                @(negedge clk);
                if (m_init) begin
                    d = m_cyc - m_T;
                    check(G, "wr_en", wr_en, in_valid & ~rst);
                    check(G, "wr_addr", wr_addr, m_wr);
                    check(G, "overrun", overrun, m_ovr);
                    check(G, "busy", busy, d >= 1 && d <= 2 * N + 2);
                    check(G, "mac_en", mac_en, d >= 2 && d <= 2 * N + 1);
                    check(G, "mac_clear", mac_clear, d == 2 || d == N + 2);
                    check(G, "dump", dump, d == N + 2 || d == 2 * N + 2);
                    if (d >= 1 && d <= 2 * N) begin
                        j = d - 1;
                        check(G, "rd_addr", rd_addr, ((m_base - (N - 1) + j % N) % D + D) % D);
                        check(G, "coef_idx", coef_idx, j % N);
                        check(G, "ch_sel", ch_sel, j / N);
                    end
                    if (d == N + 2) begin
                        check(G, "dump_ch0", dump_ch, 0);
                        check(G, "acc_ch0", acc, exp0);
                    end
                    if (d == 2 * N + 2) begin
                        check(G, "dump_ch1", dump_ch, 1);
                        check(G, "acc_ch1", acc, exp1);
                    end
                    if (m_rst) begin
                        check(G, "rst rd_addr", rd_addr, 0);
                        check(G, "rst coef_idx", coef_idx, 0);
                        check(G, "rst ch_sel", ch_sel, 0);
                        check(G, "rst dump_ch", dump_ch, 0);
                    end
                end
            end
        end

        task automatic drive(input bit v, input bit clr, input int a, input int b);
            in_valid = v; ovr_clr = clr; s0 = a; s1 = b;
            @(posedge clk); #1;
            in_valid = 1'b0; ovr_clr = 1'b0;
        endtask

        task automatic idle(input int n);
            repeat (n) drive(1'b0, 1'b0, 0, 0);
        endtask

        if (g == 0) begin : stim
            initial begin
                int busy_cnt;
                rst = 1'b1; idle(2); rst = 1'b0;
                repeat (7) drive(1'b1, 1'b0, 1, -1);
                check(G, "lit wr_addr pre", wr_addr, 7);
                drive(1'b1, 1'b0, 1, -1);
                busy_cnt = 0;
                for (int c = 1; c <= 402; c++) begin
                    if (busy) busy_cnt++;
                    case (c)
                        1: begin
                            check(G, "lit T+1 rd_addr", rd_addr, 65);
                            check(G, "lit T+1 coef", coef_idx, 0);
                            check(G, "lit T+1 ch_sel", ch_sel, 0);
                        end
                        191: check(G, "lit T+191 rd_addr", rd_addr, 255);
                        192: check(G, "lit T+192 rd_addr", rd_addr, 0);
                        199: begin
                            check(G, "lit T+199 rd_addr", rd_addr, 7);
                            check(G, "lit T+199 coef", coef_idx, 198);
                        end
                        200: begin
                            check(G, "lit T+200 rd_addr", rd_addr, 65);
                            check(G, "lit T+200 ch_sel", ch_sel, 1);
                        end
                        201: begin
                            check(G, "lit T+201 dump", dump, 1);
                            check(G, "lit T+201 dump_ch", dump_ch, 0);
                            check(G, "lit T+201 acc", acc, 199);
                        end
                        400: begin
                            check(G, "lit T+400 dump", dump, 1);
                            check(G, "lit T+400 dump_ch", dump_ch, 1);
                            check(G, "lit T+400 acc", acc, -199);
                        end
                        401: check(G, "lit T+401 busy", busy, 0);
                        default: ;
                    endcase
                    drive((c % 51) == 0, 1'b0, 1, -1);
                end
                check(G, "lit busy span", busy_cnt, 400);
                check(G, "lit no overrun", overrun, 0);

                drive(1'b1, 1'b0, 1, -1);
                repeat (7) drive(1'b1, 1'b0, 1, -1);
                idle(92);
                drive(1'b1, 1'b0, 1, -1);
                check(G, "lit overrun set", overrun, 1);
                idle(302);
                check(G, "lit idle after job", busy, 0);
                drive(1'b0, 1'b1, 0, 0);
                check(G, "lit overrun cleared", overrun, 0);

                repeat (8) drive(1'b1, 1'b0, 1, -1);
                repeat (7) drive(1'b1, 1'b0, 1, -1);
                drive(1'b1, 1'b1, 1, -1);
                check(G, "lit set beats clear", overrun, 1);
                idle(400);
                drive(1'b0, 1'b1, 0, 0);
                check(G, "lit overrun cleared 2", overrun, 0);

                repeat (8) drive(1'b1, 1'b0, 1, -1);
                repeat (8) drive(1'b1, 1'b0, 1, -1);
                idle(141);
                rst = 1'b1;
                drive(1'b0, 1'b0, 0, 0);
                check(G, "lit rst busy", busy, 0);
                check(G, "lit rst mac_en", mac_en, 0);
                check(G, "lit rst wr_addr", wr_addr, 0);
                check(G, "lit rst overrun", overrun, 0);
                rst = 1'b0;
                repeat (8) drive(1'b1, 1'b0, 1, -1);
                check(G, "lit restart rd_addr", rd_addr, 65);
                idle(402);
                done[0] = 1'b1;
            end
        end else begin : stim
            initial begin
                rst = 1'b1; idle(2); rst = 1'b0;
                drive(1'b1, 1'b0, 5, -2);
                for (int c = 1; c <= 10; c++) begin
                    if (c == 1) check(G, "lit T0+1 rd_addr", rd_addr, 5);
                    if (c == 6) begin
                        check(G, "lit T0+6 dump", dump, 1);
                        check(G, "lit T0+6 acc", acc, 26);
                    end
                    if (c == 10) begin
                        check(G, "lit T0+10 dump_ch", dump_ch, 1);
                        check(G, "lit T0+10 acc", acc, -14);
                    end
                    drive(1'b0, 1'b0, 0, 0);
                end
                drive(1'b1, 1'b0, 2, 3);
                check(G, "lit spacing 11 no overrun", overrun, 0);
                check(G, "lit T1+1 rd_addr", rd_addr, 6);
                idle(2);
                check(G, "lit T1+3 rd_addr", rd_addr, 0);
                idle(7);
                check(G, "lit T1+10 acc", acc, 3);
                drive(1'b1, 1'b0, 0, 0);
                check(G, "lit spacing 10 overrun", overrun, 1);
                idle(11);
                done[1] = 1'b1;
            end
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(done[0] && done[1]) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check(-1, "bench completion", done[0] && done[1], 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
